vec_stream_sched: RTL and testbench
===================================

Name: vec_stream_sched

Overview:
- Phase controller between the input AXI-Stream and the Tanimoto datapath.
- For one job it steers the first REF_BEATS accepted bus beats to the reference-vector load port, then a runtime-configured number of beats to the compare port.
- It then waits for the datapath to drain and reports completion and framing errors.

Parameters:
BUS_WIDTH, 128, stream data width in bits (multiple of 8, power of two)
VECTOR_WIDTH, 920, fingerprint width in bits (multiple of 8)
REF_VEC_NO, 8, reference vectors per job (compile-time)
CNT_W, 32, width of beat counters and cfg_cmp_vec_no

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cfg_cmp_vec_no  in  CNT_W  compare vectors for the next job; sampled at cfg_start
cfg_start  in  1  start pulse; ignored while busy
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
err_tlast  out  1  sticky framing error; cleared on accepted start
s_tdata  in  BUS_WIDTH  input stream data
s_tvalid  in  1  input valid
s_tlast  in  1  input last
s_tready  out  1  input ready
ref_tdata  out  BUS_WIDTH  reference load data
ref_tvalid  out  1  reference valid
ref_tready  in  1  reference ready
cmp_tdata  out  BUS_WIDTH  compare data
cmp_tvalid  out  1  compare valid
cmp_tlast  out  1  high on the final compare beat (generated internally)
cmp_tready  in  1  compare ready
dp_idle  in  1  datapath has no vectors or ID pairs in flight

Behaviour:
- Derived constants:
  - VB = VECTOR_WIDTH/8; BB = BUS_WIDTH/8.
  - REF_BEATS = ceil(REF_VEC_NO*VB/BB).
  - Each region is padded to whole beats independently.
- cmp_beats is computed when start is accepted as (cfg_cmp_vec_no*VB + BB-1) >> log2(BB), in CNT_W+8 bits internally, then registered. Defaults give REF_BEATS=58.
- States:
  - IDLE: tready low. On cfg_start: latch cmp_beats, clear the beat counter and err_tlast, set busy, go to REF.
  - REF: s_tready=ref_tready, ref_tvalid=s_tvalid, cmp_tvalid=0.
    - A beat is accepted when s_tvalid&s_tready; each accepted beat increments the counter.
    - On the REF_BEATS-th accepted beat, clear the counter and go to CMP, or to DRAIN if cmp_beats==0.
  - CMP: s_tready=cmp_tready, cmp_tvalid=s_tvalid, ref_tvalid=0.
    - cmp_tlast=(cnt==cmp_beats-1).
    - On the final accepted beat, go to DRAIN.
  - DRAIN: tready low. When dp_idle is sampled high, go to DONE.
  - DONE: done=1 for one cycle, busy drops, next state IDLE.
    - busy is low in DONE. A start in the DONE cycle is ignored.
- Data path is combinational passthrough: ref_tdata=cmp_tdata=s_tdata, zero latency, no buffering. Valid is never dropped by this block while the input holds valid.
- tlast checking (on accepted beats only):
  - s_tlast high on any beat other than the final compare beat sets err_tlast.
  - If cmp_beats==0, the final ref beat is the expected last.
  - The expected final beat with s_tlast low also sets err_tlast.
  - Errors do not alter sequencing; the beat count governs.
- Reset values:
  - State IDLE; counters 0.
  - busy, done, err_tlast, s_tready, ref_tvalid, cmp_tvalid and cmp_tlast all 0.
- Reset mid-job returns to IDLE in the next cycle. Beats in flight are abandoned, and no done pulse is issued.
- A start pulse while busy is ignored and its cfg value is not latched.

Test Plan:
- Defaults, cfg_cmp_vec_no=128, continuous valid, tlast on beat 978:
  - Beats 1-58 appear on ref, beats 59-978 on cmp.
  - cmp_tlast is high only on beat 978; err_tlast=0.
  - done pulses the cycle after dp_idle is sampled high.
- cfg_cmp_vec_no=1 → cmp_beats=8 and cmp_tlast on the 8th cmp beat. cfg_cmp_vec_no=0 → REF→DRAIN after beat 58, and no cmp_tvalid ever.
- Backpressure:
  - Toggle ref_tready and cmp_tready pseudo-randomly with 1-in-4 input valid, as in the sparse traffic mode.
  - Beat counts stay exact, s_tready mirrors the active-phase ready, and no beat is duplicated or lost (scoreboard).
- s_tlast on beat 40 (REF) → err_tlast sets and stays high; sequencing still completes with 978 beats. Missing tlast on beat 978 → err_tlast=1.
- Hold dp_idle low for 50 cycles after the last beat → busy stays high with no done. Raise dp_idle → done follows within 2 cycles.
- rstn low during CMP beat 300 → next cycle is IDLE with all outputs 0. A fresh start then runs a full, correct job.
- cfg_start pulsed during REF with a different cfg value → ignored; the original cmp_beats is used.

Source files
------------

// File: rtl/vec_stream_sched.sv
// Phase controller for one Tanimoto job: routes the reference beats, then the compare beats,
// waits for the datapath to drain, and flags tlast framing errors.
module vec_stream_sched #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int REF_VEC_NO   = 8,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CNT_W-1:0]     cfg_cmp_vec_no,
  input  logic                 cfg_start,
  output logic                 busy,
  output logic                 done,
  output logic                 err_tlast,
  input  logic [BUS_WIDTH-1:0] s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,
  output logic [BUS_WIDTH-1:0] ref_tdata,
  output logic                 ref_tvalid,
  input  logic                 ref_tready,
  output logic [BUS_WIDTH-1:0] cmp_tdata,
  output logic                 cmp_tvalid,
  output logic                 cmp_tlast,
  input  logic                 cmp_tready,
  input  logic                 dp_idle
);
  localparam int VB        = VECTOR_WIDTH / 8;
  localparam int BB        = BUS_WIDTH / 8;
  localparam int BB_LG     = $clog2(BB);
  localparam int REF_BEATS = (REF_VEC_NO * VB + BB - 1) / BB;
  localparam int EW        = CNT_W + 8;

  typedef enum logic [2:0] {IDLE, REF, CMP, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [EW-1:0] cnt, cnt_nx, cmp_beats, cmp_beats_nx, cmp_calc;
  logic          err_nx, acc, ref_last, cmp_last;

  // Compare region is padded to whole beats on its own, independent of the ref region.
  assign cmp_calc  = (EW'(cfg_cmp_vec_no) * EW'(VB) + EW'(BB - 1)) >> BB_LG;
  assign ref_tdata = s_tdata;
  assign cmp_tdata = s_tdata;
  assign acc       = s_tvalid & s_tready;
  assign ref_last  = (cnt == EW'(REF_BEATS - 1));
  assign cmp_last  = (cnt == cmp_beats - EW'(1));

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    cmp_beats_nx = cmp_beats;
    err_nx       = err_tlast;
    s_tready     = 1'b0;
    ref_tvalid   = 1'b0;
    cmp_tvalid   = 1'b0;
    cmp_tlast    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: if (cfg_start) begin
        cmp_beats_nx = cmp_calc;
        cnt_nx       = '0;
        err_nx       = 1'b0;
        state_nx     = REF;
      end
      REF: begin
        busy       = 1'b1;
        s_tready   = ref_tready;
        ref_tvalid = s_tvalid;
        if (acc) begin
          // With no compare region the last ref beat is the one that must carry tlast.
          if (s_tlast != (ref_last && cmp_beats == '0)) err_nx = 1'b1;
          if (ref_last) begin
            cnt_nx   = '0;
            state_nx = (cmp_beats == '0) ? DRAIN : CMP;
          end else begin
            cnt_nx = cnt + EW'(1);
          end
        end
      end
      CMP: begin
        busy       = 1'b1;
        s_tready   = cmp_tready;
        cmp_tvalid = s_tvalid;
        cmp_tlast  = cmp_last;
        if (acc) begin
          if (s_tlast != cmp_last) err_nx = 1'b1;
          cnt_nx = cnt + EW'(1);
          if (cmp_last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (dp_idle) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      cmp_beats <= '0;
      err_tlast <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cmp_beats <= cmp_beats_nx;
      err_tlast <= err_nx;
    end
  end
endmodule

// File: tb/tb_vec_stream_sched.sv
// Directed bench for vec_stream_sched: a beat-count model of the job checked every cycle,
// plus literal per-job expectations (beat counts, tlast position, error flag, done pulse).
module tb_vec_stream_sched;
  localparam int BW = 128;
  localparam int RB = 58;
  localparam int VB = 115;
  localparam int BB = 16;

  logic          clk = 0, rstn = 0;
  logic [31:0]   cfg_cmp_vec_no = '0;
  logic          cfg_start = 0, busy, done, err_tlast;
  logic [BW-1:0] s_tdata = '0, ref_tdata, cmp_tdata;
  logic          s_tvalid = 0, s_tlast = 0, s_tready;
  logic          ref_tvalid, ref_tready = 1, cmp_tvalid, cmp_tlast, cmp_tready = 1;
  logic          dp_idle = 1;

  vec_stream_sched dut (
    .clk(clk), .rstn(rstn), .cfg_cmp_vec_no(cfg_cmp_vec_no), .cfg_start(cfg_start),
    .busy(busy), .done(done), .err_tlast(err_tlast),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .ref_tdata(ref_tdata), .ref_tvalid(ref_tvalid), .ref_tready(ref_tready),
    .cmp_tdata(cmp_tdata), .cmp_tvalid(cmp_tvalid), .cmp_tlast(cmp_tlast),
    .cmp_tready(cmp_tready), .dp_idle(dp_idle)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: job position is just "beats accepted so far" against the two region sizes.
  bit     chk_en = 0, m_busy = 0, m_done = 0, m_err = 0;
  longint m_beats = 0, m_cmp = 0;
  int     n_ref = 0, n_cmp = 0, n_cmpv = 0, n_tl = 0, n_done = 0;
  int     tl_dat = 0;

  always @(negedge clk) if (chk_en) begin
    bit in_ref, in_cmp, in_drain, e_rdy, acc;
    in_ref   = m_busy && (m_beats < RB);
    in_cmp   = m_busy && !in_ref && (m_beats < RB + m_cmp);
    in_drain = m_busy && !in_ref && !in_cmp;
    e_rdy    = in_ref ? ref_tready : (in_cmp ? cmp_tready : 1'b0);
    acc      = s_tvalid && e_rdy;
    chk("s_tready", 64'(s_tready), 64'(e_rdy));
    chk("ref_tvalid", 64'(ref_tvalid), 64'(in_ref && s_tvalid));
    chk("cmp_tvalid", 64'(cmp_tvalid), 64'(in_cmp && s_tvalid));
    chk("cmp_tlast", 64'(cmp_tlast), 64'(in_cmp && (m_beats == RB + m_cmp - 1)));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("err_tlast", 64'(err_tlast), 64'(m_err));
    if (acc) begin
      chk("beat_order", in_ref ? ref_tdata[63:0] : cmp_tdata[63:0], 64'(m_beats + 1));
      chk("passthru", 64'(ref_tdata == s_tdata && cmp_tdata == s_tdata), 64'd1);
    end
    if (ref_tvalid && ref_tready) n_ref++;
    if (cmp_tvalid && cmp_tready) n_cmp++;
    if (cmp_tvalid) n_cmpv++;
    if (cmp_tvalid && cmp_tready && cmp_tlast) begin n_tl++; tl_dat = int'(cmp_tdata[31:0]); end
    if (done) n_done++;
    // Advance to the state after the coming posedge.
    if (!rstn) begin
      m_busy = 0; m_done = 0; m_err = 0; m_beats = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (cfg_start) begin
        m_busy = 1; m_beats = 0; m_err = 0;
        m_cmp = (longint'(cfg_cmp_vec_no) * VB + BB - 1) / BB;
      end
    end else if (acc) begin
      if (s_tlast != (m_beats + 1 == RB + m_cmp)) m_err = 1;
      m_beats++;
    end else if (in_drain && dp_idle) begin
      m_busy = 0; m_done = 1;
    end
  end

  task automatic start_job(input int cfg);
    @(posedge clk); #1 cfg_cmp_vec_no = cfg; cfg_start = 1;
    @(posedge clk); #1 cfg_start = 0;
  endtask

  // Presents beats 1..total (data = beat number), holding each until accepted.
  task automatic stream(input int total, input int tlast_at, input bit sparse, input bit bp,
                        input int abort_at, input int mid_start);
    int k = 1, guard = 0;
    bit acc;
    s_tvalid = sparse ? ($urandom_range(3) == 0) : 1'b1;
    while (k <= total && guard < 20000) begin
      s_tdata    = BW'(k);
      s_tlast    = (k == tlast_at);
      ref_tready = bp ? 1'($urandom_range(1)) : 1'b1;
      cmp_tready = bp ? 1'($urandom_range(1)) : 1'b1;
      if (k == abort_at) begin
        s_tvalid = 1; rstn = 0;
        @(posedge clk); #1 rstn = 1;
        return;
      end
      if (k == mid_start) begin cfg_cmp_vec_no = 5; cfg_start = 1; end
      @(negedge clk); acc = s_tvalid && s_tready;
      @(posedge clk); #1 cfg_start = 0;
      if (acc) k++;
      if (acc || !s_tvalid) s_tvalid = sparse ? ($urandom_range(3) == 0) : 1'b1;
      guard++;
    end
    if (guard >= 20000) chk("stream_budget", 64'(k), 64'(total + 1));
    s_tvalid = 0; s_tlast = 0; ref_tready = 1; cmp_tready = 1;
  endtask

  task automatic finish_job(input int hold);
    bit bsy = 1, nod = 1;
    int w;
    if (hold > 0) begin
      repeat (hold) begin @(negedge clk); bsy &= busy; nod &= !done; end
      chk("drain_busy_held", 64'(bsy), 64'd1);
      chk("drain_no_done", 64'(nod), 64'd1);
      @(posedge clk); #1 dp_idle = 1;
    end
    for (w = 0; w < 4; w++) begin @(negedge clk); if (done) break; end
    chk("done_within_2", 64'(w < 2), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic run(input int cfg, input int tlast_at, input bit sparse, input bit bp,
                     input int hold, input int mid, input int exp_cmp, input bit exp_err);
    int r0, c0, v0, t0, d0;
    r0 = n_ref; c0 = n_cmp; v0 = n_cmpv; t0 = n_tl; d0 = n_done;
    dp_idle = (hold == 0);
    start_job(cfg);
    stream(RB + exp_cmp, tlast_at, sparse, bp, 0, mid);
    finish_job(hold);
    chk("job_ref_beats", 64'(n_ref - r0), 64'd58);
    chk("job_cmp_beats", 64'(n_cmp - c0), 64'(exp_cmp));
    chk("job_err_tlast", 64'(err_tlast), 64'(exp_err));
    chk("job_done_pulses", 64'(n_done - d0), 64'd1);
    if (exp_cmp > 0) begin
      chk("job_cmp_tlast_cnt", 64'(n_tl - t0), 64'd1);
      chk("job_cmp_tlast_beat", 64'(tl_dat), 64'(RB + exp_cmp));
    end else begin
      chk("job_no_cmp_valid", 64'(n_cmpv - v0), 64'd0);
    end
  endtask

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1; s_tvalid = 1;
    @(negedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_tlast), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_valids", 64'({ref_tvalid, cmp_tvalid, cmp_tlast}), 64'd0);
    s_tvalid = 0;

    run(128, 978, 0, 0, 0,  0, 920, 0);  // defaults, continuous valid
    run(1,   66,  0, 0, 0,  0, 8,   0);  // one compare vector -> 8 beats
    run(0,   58,  0, 0, 0,  0, 0,   0);  // no compare region
    run(2,   73,  1, 1, 0, 10, 15,  0);  // sparse + backpressure, ignored restart
    run(128, 40,  0, 0, 0,  0, 920, 1);  // early tlast in ref region
    run(1,   0,   0, 0, 50, 0, 8,   1);  // missing tlast, slow drain

    // Reset during compare beat 300 (beat 358 overall).
    d0 = n_done;
    dp_idle = 1;
    start_job(128);
    stream(978, 978, 0, 0, 358, 0);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_tready", 64'(s_tready), 64'd0);
    chk("abort_valids", 64'({ref_tvalid, cmp_tvalid, cmp_tlast, done, err_tlast}), 64'd0);
    s_tvalid = 0; s_tlast = 0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(n_done - d0), 64'd0);
    run(128, 978, 0, 1, 0, 0, 920, 0);   // fresh full job after reset

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule
